// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency imem reads and buffers
// words in a DEPTH-entry prefetch FIFO. Define FETCH_QUEUE_PERF_EN for perf counters.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_rd_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_instr,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [INSTR_W-1:0]       id_instr,
  output logic [ADDR_W-1:0]        id_pc_next,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     halt,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_flush_cnt,
  output logic [31:0]              perf_stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0]  pc_q;
  logic               halted_q;
  logic               inflight_q;
  logic [PtrW-1:0]    wr_ptr_q;
  logic [PtrW-1:0]    rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pcn_q   [DEPTH];

  logic [CntW-1:0] occupancy;
  logic            push;
  logic            pop;

  always_comb begin
    // Slots are reserved at issue, so in-flight words count against capacity.
    occupancy  = count_q + CntW'(inflight_q);
    imem_rd_en = ~rst & ~halted_q & ~halt & ~redirect_valid & (occupancy < CntW'(DEPTH));
    imem_addr  = pc_q;
    id_valid   = (count_q != '0);
    id_instr   = instr_q[rd_ptr_q];
    id_pc_next = pcn_q[rd_ptr_q];
    count      = count_q;
    push       = inflight_q & ~redirect_valid;
    pop        = id_valid & id_ready & ~redirect_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      halted_q   <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pcn_q[i]   <= '0;
      end
    end else begin
      inflight_q <= imem_rd_en;
      if (halt) begin
        halted_q <= 1'b1;
      end
      if (redirect_valid) begin
        pc_q     <= redirect_pc;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (imem_rd_en) begin
          pc_q <= pc_q + ADDR_W'(1);
        end
        if (push) begin
          // pc_q already advanced past the returning word, so it is that word's address+1.
          instr_q[wr_ptr_q] <= imem_instr;
          pcn_q[wr_ptr_q]   <= pc_q;
          wr_ptr_q          <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] fetch_q;
  logic [31:0] flush_q;
  logic [31:0] stall_q;
  logic [32:0] flush_sum;

  always_comb begin
    flush_sum      = {1'b0, flush_q} + 33'(occupancy);
    perf_fetch_cnt = fetch_q;
    perf_flush_cnt = flush_q;
    perf_stall_cnt = stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q <= '0;
      flush_q <= '0;
      stall_q <= '0;
    end else begin
      if (push && (fetch_q != '1)) begin
        fetch_q <= fetch_q + 32'd1;
      end
      if (redirect_valid) begin
        flush_q <= flush_sum[32] ? '1 : flush_sum[31:0];
      end
      if (id_valid && !id_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; a second instance covers RESET_PC wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [15:0] id_instr;
  logic [15:0] id_pc_next;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [2:0]  count;

  logic        rst_w = 1'b1;
  logic        rd_en_w;
  logic [15:0] addr_w;
  logic [15:0] instr_in_w = '0;
  logic        valid_w;
  logic [15:0] instr_w;
  logic [15:0] pcn_w;
  logic [2:0]  count_w;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
  logic [31:0] pf_w, pfl_w, ps_w;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc_next(id_pc_next), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt),
`ifdef FETCH_QUEUE_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .count(count)
  );

  fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst_w), .imem_rd_en(rd_en_w), .imem_addr(addr_w),
    .imem_instr(instr_in_w), .id_valid(valid_w), .id_ready(1'b1), .id_instr(instr_w),
    .id_pc_next(pcn_w), .redirect_valid(1'b0), .redirect_pc(16'h0000), .halt(1'b0),
`ifdef FETCH_QUEUE_PERF_EN
    .perf_fetch_cnt(pf_w), .perf_flush_cnt(pfl_w), .perf_stall_cnt(ps_w),
`endif
    .count(count_w)
  );

  // Synchronous instruction memory: mem[a] = a ^ 16'hA5A5.
  always @(posedge clk) begin
    imem_instr <= imem_addr ^ 16'hA5A5;
    instr_in_w <= addr_w ^ 16'hA5A5;
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench 3 time units into cycle 0 after release.
  task automatic do_reset(input logic ready);
    id_ready = ready;
    halt = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total_cnt++;
    if (imem_rd_en !== 1'b0 || id_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL reset_ctrl got rd_en=%b valid=%b count=%0d want 0/0/0",
               imem_rd_en, id_valid, count);
    else pass_cnt++;
    total_cnt++;
    if (id_instr !== 16'h0 || id_pc_next !== 16'h0)
      $display("FAIL reset_data got instr=%h pcn=%h want 0000/0000", id_instr, id_pc_next);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    total_cnt++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0 || id_valid !== 1'b0)
      $display("FAIL stream_c0 got rd_en=%b addr=%h valid=%b want 1/0000/0",
               imem_rd_en, imem_addr, id_valid);
    else pass_cnt++;
    nxt(); #1;
    total_cnt++;
    if (imem_addr !== 16'h1 || id_valid !== 1'b0)
      $display("FAIL stream_c1 got addr=%h valid=%b want 0001/0", imem_addr, id_valid);
    else pass_cnt++;
    for (int k = 2; k < 8; k++) begin
      nxt(); #1;
      total_cnt++;
      if (imem_addr !== 16'(k) || id_valid !== 1'b1 || id_instr !== (16'(k - 2) ^ 16'hA5A5)
          || id_pc_next !== 16'(k - 1) || count !== 3'd1)
        $display("FAIL stream_c%0d got addr=%h valid=%b instr=%h pcn=%h count=%0d", k,
                 imem_addr, id_valid, id_instr, id_pc_next, count);
      else pass_cnt++;
    end
  endtask

  task automatic test_full();
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin nxt(); #1; end
      total_cnt++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 16'(k))
        $display("FAIL full_req%0d got rd_en=%b addr=%h want 1/%h", k, imem_rd_en,
                 imem_addr, 16'(k));
      else pass_cnt++;
    end
    for (int k = 4; k < 8; k++) begin
      nxt(); #1;
      total_cnt++;
      if (imem_rd_en !== 1'b0)
        $display("FAIL full_norq_c%0d got rd_en=%b want 0", k, imem_rd_en);
      else pass_cnt++;
      if (k >= 5) begin
        total_cnt++;
        if (count !== 3'd4 || id_valid !== 1'b1 || id_instr !== 16'hA5A5)
          $display("FAIL full_hold_c%0d got count=%0d valid=%b instr=%h want 4/1/a5a5", k,
                   count, id_valid, id_instr);
        else pass_cnt++;
      end
    end
    nxt();
    id_ready = 1'b1;
    #1;
    total_cnt++;
    if (imem_rd_en !== 1'b0 || id_instr !== 16'hA5A5 || id_pc_next !== 16'h1)
      $display("FAIL full_pop0 got rd_en=%b instr=%h pcn=%h want 0/a5a5/0001", imem_rd_en,
               id_instr, id_pc_next);
    else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      nxt(); #1;
      total_cnt++;
      if (id_valid !== 1'b1 || id_instr !== (16'(k) ^ 16'hA5A5) || id_pc_next !== 16'(k + 1))
        $display("FAIL full_pop%0d got valid=%b instr=%h pcn=%h", k, id_valid, id_instr,
                 id_pc_next);
      else pass_cnt++;
      if (k == 1) begin
        total_cnt++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 16'h4)
          $display("FAIL full_resume got rd_en=%b addr=%h want 1/0004", imem_rd_en, imem_addr);
        else pass_cnt++;
      end
    end
    nxt(); #1;
    total_cnt++;
    if (id_instr !== (16'h4 ^ 16'hA5A5) || id_pc_next !== 16'h5)
      $display("FAIL full_pop4 got instr=%h pcn=%h want a5a1/0005", id_instr, id_pc_next);
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) nxt();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    total_cnt++;
    if (imem_rd_en !== 1'b0 || count !== 3'd3)
      $display("FAIL redir_r got rd_en=%b count=%0d want 0/3", imem_rd_en, count);
    else pass_cnt++;
    nxt();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    #1;
    total_cnt++;
    if (count !== 3'd0 || id_valid !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 16'h0040)
      $display("FAIL redir_r1 got count=%0d valid=%b rd_en=%b addr=%h want 0/0/1/0040", count,
               id_valid, imem_rd_en, imem_addr);
    else pass_cnt++;
`ifdef FETCH_QUEUE_PERF_EN
    total_cnt++;
    if (perf_flush_cnt !== 32'd4)
      $display("FAIL perf_flush got %0d want 4", perf_flush_cnt);
    else pass_cnt++;
`endif
    nxt(); #1;
    total_cnt++;
    if (id_valid !== 1'b0 || imem_addr !== 16'h0041)
      $display("FAIL redir_r2 got valid=%b addr=%h want 0/0041", id_valid, imem_addr);
    else pass_cnt++;
    nxt(); #1;
    total_cnt++;
    if (id_valid !== 1'b1 || id_pc_next !== 16'h0041 || id_instr !== 16'hA5E5 || count !== 3'd1)
      $display("FAIL redir_r3 got valid=%b pcn=%h instr=%h count=%0d want 1/0041/a5e5/1",
               id_valid, id_pc_next, id_instr, count);
    else pass_cnt++;
    nxt(); #1;
    total_cnt++;
    if (id_pc_next !== 16'h0042)
      $display("FAIL redir_r4 got pcn=%h want 0042", id_pc_next);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    @(posedge clk);
    #2;
    rst_w = 1'b0;
    #1;
    total_cnt++;
    if (rd_en_w !== 1'b1 || addr_w !== 16'hFFFE)
      $display("FAIL wrap_c0 got rd_en=%b addr=%h want 1/fffe", rd_en_w, addr_w);
    else pass_cnt++;
    nxt(); #1;
    total_cnt++;
    if (addr_w !== 16'hFFFF)
      $display("FAIL wrap_c1 got addr=%h want ffff", addr_w);
    else pass_cnt++;
    nxt(); #1;
    total_cnt++;
    if (addr_w !== 16'h0000 || valid_w !== 1'b1 || pcn_w !== 16'hFFFF || instr_w !== 16'h5A5B)
      $display("FAIL wrap_c2 got addr=%h valid=%b pcn=%h instr=%h want 0000/1/ffff/5a5b",
               addr_w, valid_w, pcn_w, instr_w);
    else pass_cnt++;
    nxt(); #1;
    total_cnt++;
    if (addr_w !== 16'h0001 || pcn_w !== 16'h0000 || instr_w !== 16'h5A5A)
      $display("FAIL wrap_c3 got addr=%h pcn=%h instr=%h want 0001/0000/5a5a", addr_w, pcn_w,
               instr_w);
    else pass_cnt++;
    rst_w = 1'b1;
  endtask

  task automatic test_halt();
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) nxt();
    halt = 1'b1;
    #1;
    total_cnt++;
    if (imem_rd_en !== 1'b0 || count !== 3'd2)
      $display("FAIL halt_c3 got rd_en=%b count=%0d want 0/2", imem_rd_en, count);
    else pass_cnt++;
    nxt();
    halt = 1'b0;
    id_ready = 1'b1;
    #1;
    total_cnt++;
    if (imem_rd_en !== 1'b0 || count !== 3'd3)
      $display("FAIL halt_c4 got rd_en=%b count=%0d want 0/3", imem_rd_en, count);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin nxt(); #1; end
      total_cnt++;
      if (id_valid !== 1'b1 || id_instr !== (16'(k) ^ 16'hA5A5) || imem_rd_en !== 1'b0)
        $display("FAIL halt_drain%0d got valid=%b instr=%h rd_en=%b", k, id_valid, id_instr,
                 imem_rd_en);
      else pass_cnt++;
    end
    for (int k = 0; k < 2; k++) begin
      nxt(); #1;
      total_cnt++;
      if (id_valid !== 1'b0 || imem_rd_en !== 1'b0)
        $display("FAIL halt_idle%0d got valid=%b rd_en=%b want 0/0", k, id_valid, imem_rd_en);
      else pass_cnt++;
    end
    nxt();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    nxt();
    redirect_valid = 1'b0;
    #1;
    total_cnt++;
    if (imem_rd_en !== 1'b0 || imem_addr !== 16'h0080 || id_valid !== 1'b0)
      $display("FAIL halt_redir got rd_en=%b addr=%h valid=%b want 0/0080/0", imem_rd_en,
               imem_addr, id_valid);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) nxt();
    #1;
    total_cnt++;
    if (count !== 3'd4)
      $display("FAIL midrst_pre got count=%0d want 4", count);
    else pass_cnt++;
`ifdef FETCH_QUEUE_PERF_EN
    total_cnt++;
    if (perf_fetch_cnt !== 32'd4 || perf_stall_cnt !== 32'd4)
      $display("FAIL perf_pre got fetch=%0d stall=%0d want 4/4", perf_fetch_cnt,
               perf_stall_cnt);
    else pass_cnt++;
`endif
    rst = 1'b1;
    #1;
    total_cnt++;
    if (id_valid !== 1'b0 || count !== 3'd0 || imem_rd_en !== 1'b0 || id_instr !== 16'h0
        || id_pc_next !== 16'h0)
      $display("FAIL midrst_async got valid=%b count=%0d rd_en=%b instr=%h pcn=%h", id_valid,
               count, imem_rd_en, id_instr, id_pc_next);
    else pass_cnt++;
`ifdef FETCH_QUEUE_PERF_EN
    total_cnt++;
    if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL perf_rst got %0d/%0d/%0d want 0/0/0", perf_fetch_cnt, perf_flush_cnt,
               perf_stall_cnt);
    else pass_cnt++;
`endif
    nxt();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0000 || count !== 3'd0)
      $display("FAIL midrst_rel got rd_en=%b addr=%h count=%0d want 1/0000/0", imem_rd_en,
               imem_addr, count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_halt();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
